// File: rtl/count_hex_uart_tx.sv
// count_hex_uart_tx: watches a 4-bit count and, whenever it changes, sends the
// new value as one ASCII hex character (optionally followed by LF) on an 8N1
// serial line. Changes that arrive during a transmission are coalesced into a
// single pending slot, so the most recent value wins.
module count_hex_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit SEND_NEWLINE = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] COUNT_IN,
  input  logic       EN,
  output logic       TXD,
  output logic       BUSY,
  output logic       SENT_STB
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          byte_sel_q, byte_sel_d;
  logic [3:0]    pend_val_q, pend_val_d;
  logic          pend_vld_q, pend_vld_d;
  logic [3:0]    last_sent_q, last_sent_d;
  logic          last_vld_q, last_vld_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          stb_q, stb_d;

  logic          baud_done;
  logic          load;
  logic [3:0]    ref_val;
  logic          ref_vld;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 + {4'h0, n};
    else           return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  assign baud_done = (baud_q == BAUD_LAST);
  assign load      = (state_q == S_IDLE) && pend_vld_q;
  // On the load edge the value being launched is the reference for change
  // detection, otherwise a steady input would be re-captured and sent twice.
  assign ref_val   = load ? pend_val_q : last_sent_q;
  assign ref_vld   = load | last_vld_q;

  // Next-state logic: transmitter FSM followed by change capture.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    byte_sel_d  = byte_sel_q;
    pend_val_d  = pend_val_q;
    pend_vld_d  = pend_vld_q;
    last_sent_d = last_sent_q;
    last_vld_d  = last_vld_q;
    txd_d       = txd_q;
    busy_d      = busy_q;
    stb_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (load) begin
          shreg_d     = hex_ascii(pend_val_q);
          last_sent_d = pend_val_q;
          last_vld_d  = 1'b1;
          pend_vld_d  = 1'b0;
          busy_d      = 1'b1;
          txd_d       = 1'b0;
          baud_d      = '0;
          bit_d       = '0;
          byte_sel_d  = 1'b0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          txd_d   = shreg_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            shreg_d = {1'b0, shreg_q[7:1]};
            txd_d   = shreg_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (SEND_NEWLINE && !byte_sel_q) begin
            // Second frame follows immediately with no idle gap.
            shreg_d    = 8'h0A;
            byte_sel_d = 1'b1;
            txd_d      = 1'b0;
            state_d    = S_START;
          end else begin
            byte_sel_d = 1'b0;
            busy_d     = 1'b0;
            stb_d      = 1'b1;
            txd_d      = 1'b1;
            state_d    = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Capture overrides the slot clear so a change on the load edge is kept.
    if (EN && (!ref_vld || (COUNT_IN != ref_val))) begin
      pend_val_d = COUNT_IN;
      pend_vld_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset (line returns idle at once).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      byte_sel_q  <= 1'b0;
      pend_val_q  <= '0;
      pend_vld_q  <= 1'b0;
      last_sent_q <= '0;
      last_vld_q  <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      byte_sel_q  <= byte_sel_d;
      pend_val_q  <= pend_val_d;
      pend_vld_q  <= pend_vld_d;
      last_sent_q <= last_sent_d;
      last_vld_q  <= last_vld_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      stb_q       <= stb_d;
    end
  end

  assign TXD      = txd_q;
  assign BUSY     = busy_q;
  assign SENT_STB = stb_q;

endmodule
